// File: rtl/uart_pkg.sv
// Shared types, divisor arithmetic and parameter legality for the UART FIFO transceiver.
package uart_pkg;

    typedef logic [2:0] tx_state_e;
    localparam tx_state_e TxIdle   = 3'd0;
    localparam tx_state_e TxStart  = 3'd1;
    localparam tx_state_e TxData   = 3'd2;
    localparam tx_state_e TxParity = 3'd3;
    localparam tx_state_e TxStop   = 3'd4;

    typedef logic [2:0] rx_state_e;
    localparam rx_state_e RxIdle   = 3'd0;
    localparam rx_state_e RxStart  = 3'd1;
    localparam rx_state_e RxData   = 3'd2;
    localparam rx_state_e RxParity = 3'd3;
    localparam rx_state_e RxStop   = 3'd4;

    // Rounded clock cycles per bit.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int unsigned data_bits, input int unsigned stop_bits,
                                     input int unsigned depth, input int unsigned div);
        return (data_bits >= 5) && (data_bits <= 9) && (stop_bits == 1 || stop_bits == 2) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0) && (div >= 4);
    endfunction

endpackage

// File: rtl/uart_fifo_xcvr_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on rdata_o while not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    core_clk,
    input  logic                    core_rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic                    full_o,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge core_clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_xcvr.sv
// Parametrised UART transceiver with TX/RX FIFOs and per-byte / per-event line error reporting.
module uart_fifo_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              core_clk,
    input  logic                              core_rst_n,
    input  logic [DATA_BITS-1:0]              tx_data_i,
    input  logic                              tx_valid_i,
    output logic                              tx_ready_o,
    output logic [DATA_BITS-1:0]              rx_data_o,
    output logic                              rx_parity_err_o,
    output logic                              rx_valid_o,
    input  logic                              rx_ready_i,
    output logic                              rx_frame_err_o,
    output logic                              rx_overrun_o,
    output logic [level_w(FIFO_DEPTH)-1:0]    tx_level_o,
    output logic [level_w(FIFO_DEPTH)-1:0]    rx_level_o,
    output logic                              tx_busy_o,
    output logic                              ser_tx,
    input  logic                              ser_rx
);
    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUDRATE);
    localparam int unsigned CntW = $clog2(STOP_BITS * DIV);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic        ParEn  = (PARITY_EN != 0);
    localparam logic        ParOdd = (PARITY_ODD != 0);

    if (!params_ok(DATA_BITS, STOP_BITS, FIFO_DEPTH, DIV)) begin : g_param_check
        $fatal(1, "uart_fifo_xcvr: illegal parameter set");
    end

    // ---------------- TX ----------------
    logic                 tx_full, tx_empty, tx_pop, tx_load;
    logic [DATA_BITS-1:0] tx_rdata;
    tx_state_e            tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, ser_tx_q, ser_tx_d;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .push_i     (tx_valid_i),
        .wdata_i    (tx_data_i),
        .full_o     (tx_full),
        .pop_i      (tx_pop),
        .rdata_o    (tx_rdata),
        .empty_o    (tx_empty),
        .level_o    (tx_level_o)
    );

    assign tx_ready_o = ~tx_full;
    assign tx_busy_o  = (tx_state_q != TxIdle);
    assign ser_tx     = ser_tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        ser_tx_d   = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                tx_load  = ~tx_empty;
            end
            TxStart: begin
                ser_tx_d = 1'b0;
                if (tx_cnt_q == CntW'(DIV - 1)) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            TxData: begin
                ser_tx_d = tx_shift_q[0];
                if (tx_cnt_q == CntW'(DIV - 1)) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == BitW'(DATA_BITS - 1)) tx_state_d = ParEn ? TxParity : TxStop;
                end
            end
            TxParity: begin
                ser_tx_d = tx_par_q;
                if (tx_cnt_q == CntW'(DIV - 1)) begin
                    tx_state_d = TxStop;
                    tx_cnt_d   = '0;
                end
            end
            TxStop: begin
                if (tx_cnt_q == CntW'(STOP_BITS * DIV - 1)) begin
                    tx_state_d = TxIdle;
                    tx_cnt_d   = '0;
                    tx_load    = ~tx_empty;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        // Loading straight from STOP gives back-to-back frames with no idle gap.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_rdata;
            tx_par_d   = ^tx_rdata ^ ParOdd;
            tx_state_d = TxStart;
            tx_cnt_d   = '0;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            ser_tx_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            ser_tx_q   <= ser_tx_d;
        end
    end

    // ---------------- RX ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d, rx_tick, rx_push, rx_full, rx_empty, rx_perr;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [DATA_BITS:0]   rx_rdata;

    sync_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .push_i     (rx_push),
        .wdata_i    ({rx_perr, rx_shift_q}),
        .full_o     (rx_full),
        .pop_i      (rx_ready_i),
        .rdata_o    (rx_rdata),
        .empty_o    (rx_empty),
        .level_o    (rx_level_o)
    );

    assign rx_data_o       = rx_rdata[DATA_BITS-1:0];
    assign rx_parity_err_o = rx_rdata[DATA_BITS];
    assign rx_valid_o      = ~rx_empty;
    assign rx_frame_err_o  = frame_err_q;
    assign rx_overrun_o    = overrun_q;
    assign rx_perr         = ParEn & (^rx_shift_q ^ rx_par_q ^ ParOdd);
    // Start bit is checked half a bit in; every later sample is a full bit after the previous.
    assign rx_tick = (rx_cnt_q == ((rx_state_q == RxStart) ? CntW'(DIV / 2 - 1) : CntW'(DIV - 1)));

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_push     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == BitW'(DATA_BITS - 1)) rx_state_d = ParEn ? RxParity : RxStop;
                end
            end
            RxParity: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s2_q;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    if (!rx_s2_q)     frame_err_d = 1'b1;
                    else if (rx_full) overrun_d   = 1'b1;
                    else              rx_push     = 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_s1_q     <= ser_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_q    <= rx_par_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// Scoreboard bench: default-config instance (A) plus an odd-parity instance (B).
module tb_uart_fifo_xcvr;
    localparam int unsigned DIV = 217;

    logic       core_clk, core_rst_n;
    logic [7:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
    logic       tx_valid_a, tx_ready_a, rx_perr_a, rx_valid_a, rdy_a, ferr_a, ovr_a;
    logic       tx_busy_a, ser_tx_a, ser_rx_a, loop_a, line_a;
    logic       tx_valid_b, tx_ready_b, rx_perr_b, rx_valid_b, rdy_b, ferr_b, ovr_b;
    logic       tx_busy_b, ser_tx_b, line_b;
    logic [4:0] tx_level_a, rx_level_a, tx_level_b, rx_level_b;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_cnt = 0, ferr_run = 0, ferr_max = 0;
    int ovr_cnt = 0, ovr_run = 0, ovr_max = 0;
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];

    assign ser_rx_a = loop_a ? ser_tx_a : line_a;

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    uart_fifo_xcvr u_dut_a (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .tx_data_i(tx_data_a), .tx_valid_i(tx_valid_a), .tx_ready_o(tx_ready_a),
        .rx_data_o(rx_data_a), .rx_parity_err_o(rx_perr_a), .rx_valid_o(rx_valid_a),
        .rx_ready_i(rdy_a), .rx_frame_err_o(ferr_a), .rx_overrun_o(ovr_a),
        .tx_level_o(tx_level_a), .rx_level_o(rx_level_a), .tx_busy_o(tx_busy_a),
        .ser_tx(ser_tx_a), .ser_rx(ser_rx_a)
    );

    uart_fifo_xcvr #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut_b (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b), .tx_ready_o(tx_ready_b),
        .rx_data_o(rx_data_b), .rx_parity_err_o(rx_perr_b), .rx_valid_o(rx_valid_b),
        .rx_ready_i(rdy_b), .rx_frame_err_o(ferr_b), .rx_overrun_o(ovr_b),
        .tx_level_o(tx_level_b), .rx_level_o(rx_level_b), .tx_busy_o(tx_busy_b),
        .ser_tx(ser_tx_b), .ser_rx(line_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] v);
        tx_data_a  = v;
        tx_valid_a = 1'b1;
        @(posedge core_clk);
        #1;
        tx_valid_a = 1'b0;
    endtask

    task automatic drive_line(input bit to_b, input logic v);
        if (to_b) line_b = v;
        else      line_a = v;
    endtask

    task automatic send_frame(input bit to_b, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop_bit);
        drive_line(to_b, 1'b0);
        cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            drive_line(to_b, d[i]);
            cycles(DIV);
        end
        if (par_en) begin
            drive_line(to_b, par_bit);
            cycles(DIV);
        end
        drive_line(to_b, stop_bit);
        cycles(DIV);
        drive_line(to_b, 1'b1);
    endtask

    initial begin : mon_a
        logic [8:0] e;
        forever begin
            @(negedge core_clk);
            if (core_rst_n && rx_valid_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    check_eq("rx_a_unexpected", 32'(exp_a.size()), 32'd1);
                end else begin
                    e = exp_a.pop_front();
                    check_eq("rx_a_entry", {23'd0, rx_perr_a, rx_data_a}, {23'd0, e});
                end
            end
        end
    end

    initial begin : mon_b
        logic [8:0] e;
        forever begin
            @(negedge core_clk);
            if (core_rst_n && rx_valid_b && rdy_b) begin
                if (exp_b.size() == 0) begin
                    check_eq("rx_b_unexpected", 32'(exp_b.size()), 32'd1);
                end else begin
                    e = exp_b.pop_front();
                    check_eq("rx_b_entry", {23'd0, rx_perr_b, rx_data_b}, {23'd0, e});
                end
            end
        end
    end

    initial begin : mon_pulse
        forever begin
            @(negedge core_clk);
            if (ferr_a) begin
                ferr_cnt++;
                ferr_run++;
                if (ferr_run > ferr_max) ferr_max = ferr_run;
            end else ferr_run = 0;
            if (ovr_a) begin
                ovr_cnt++;
                ovr_run++;
                if (ovr_run > ovr_max) ovr_max = ovr_run;
            end else ovr_run = 0;
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [9:0] frame;
        logic [7:0] vals [4];
        logic       p;
        int         busy_cnt;

        vals = '{8'h55, 8'hAA, 8'h00, 8'hFF};
        tx_data_a = '0; tx_valid_a = 1'b0; rdy_a = 1'b1; loop_a = 1'b0; line_a = 1'b1;
        tx_data_b = '0; tx_valid_b = 1'b0; rdy_b = 1'b1; line_b = 1'b1;
        core_rst_n = 1'b0;
        cycles(3);
        check_eq("rst_ser_tx", ser_tx_a, 1);
        check_eq("rst_tx_ready", tx_ready_a, 1);
        check_eq("rst_rx_valid", rx_valid_a, 0);
        check_eq("rst_busy", tx_busy_a, 0);
        check_eq("rst_levels", {tx_level_a, rx_level_a}, 0);
        check_eq("rst_pulses", {ferr_a, ovr_a}, 0);
        core_rst_n = 1'b1;
        cycles(2);
        check_eq("post_rst_ser_tx", ser_tx_a, 1);

        // 1: single frame, exact bit timing at both ends of every bit slot.
        push_a(8'h68);
        check_eq("t1_tx_level", tx_level_a, 1);
        cycles(1);
        check_eq("t1_pre_start", ser_tx_a, 1);
        cycles(1);
        frame = {1'b1, 8'h68, 1'b0};
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("t1_slot%0d_first", i), ser_tx_a, frame[i]);
            cycles(DIV - 1);
            check_eq($sformatf("t1_slot%0d_last", i), ser_tx_a, frame[i]);
            cycles(1);
        end
        check_eq("t1_idle_line", ser_tx_a, 1);
        check_eq("t1_busy_done", tx_busy_a, 0);

        // 2: loopback, four back-to-back frames.
        loop_a = 1'b1;
        cycles(2);
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back({1'b0, vals[i]});
            push_a(vals[i]);
        end
        check_eq("t2_tx_level", tx_level_a, 3);
        // Busy rose one edge after the first push; sampling starts two edges later.
        busy_cnt = 0;
        while (tx_busy_a && busy_cnt < 50 * DIV) begin
            cycles(1);
            busy_cnt++;
        end
        check_eq("t2_busy_cycles", busy_cnt, 40 * DIV - 2);
        cycles(DIV);
        check_eq("t2_rx_drained", exp_a.size(), 0);
        check_eq("t2_no_ferr", ferr_cnt, 0);
        check_eq("t2_no_ovr", ovr_cnt, 0);

        // 4: bad stop bit drops the frame, then a good frame.
        loop_a = 1'b0;
        cycles(DIV);
        send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        cycles(DIV);
        check_eq("t4_ferr_count", ferr_cnt, 1);
        check_eq("t4_ferr_width", ferr_max, 1);
        check_eq("t4_rx_level", rx_level_a, 0);
        exp_a.push_back({1'b0, 8'h42});
        send_frame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
        cycles(DIV);
        check_eq("t4_good_rx", exp_a.size(), 0);

        // 5: overrun on the 17th frame with the consumer stalled.
        rdy_a = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_a.push_back({1'b0, 8'(i)});
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        cycles(DIV);
        check_eq("t5_rx_level_full", rx_level_a, 16);
        check_eq("t5_ovr_count", ovr_cnt, 1);
        check_eq("t5_ovr_width", ovr_max, 1);
        check_eq("t5_ferr_same", ferr_cnt, 1);
        rdy_a = 1'b1;
        cycles(40);
        check_eq("t5_drained", exp_a.size(), 0);
        check_eq("t5_rx_level_empty", rx_level_a, 0);

        // 6a: short low pulse is a glitch, not a frame.
        line_a = 1'b0;
        cycles(50);
        line_a = 1'b1;
        cycles(3 * DIV);
        check_eq("t6_glitch_level", rx_level_a, 0);
        check_eq("t6_glitch_flags", ferr_cnt + ovr_cnt, 2);

        // 6b: async reset in the middle of a data bit.
        push_a(8'h00);
        push_a(8'h00);
        cycles(3 * DIV);
        check_eq("t6_mid_frame_low", ser_tx_a, 0);
        check_eq("t6_pending_level", tx_level_a, 1);
        #2 core_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ser_tx", ser_tx_a, 1);
        check_eq("t6_rst_levels", {tx_level_a, rx_level_a}, 0);
        check_eq("t6_rst_busy", tx_busy_a, 0);
        check_eq("t6_rst_ready", tx_ready_a, 1);
        cycles(2);
        core_rst_n = 1'b1;
        cycles(2);
        loop_a = 1'b1;
        exp_a.push_back({1'b0, 8'h5A});
        push_a(8'h5A);
        cycles(11 * DIV);
        check_eq("t6_after_rst_rx", exp_a.size(), 0);
        check_eq("t6_after_rst_busy", tx_busy_a, 0);
        check_eq("t6_after_rst_ferr", ferr_cnt, 1);

        // 3: odd parity on instance B, correct then inverted parity bit.
        p = ^(8'h68) ^ 1'b1;
        exp_b.push_back({1'b0, 8'h68});
        send_frame(1'b1, 8'h68, 1'b1, p, 1'b1);
        cycles(DIV);
        exp_b.push_back({1'b1, 8'h68});
        send_frame(1'b1, 8'h68, 1'b1, ~p, 1'b1);
        cycles(DIV);
        check_eq("t3_parity_rx", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_xcvr.md
Name: uart_fifo_xcvr

Overview:
Synthesizable, parametrised UART transceiver for the cv32e40x SoC. It replaces the fixed 8N1 serial path with configurable data width, parity and stop bits. Separate TX and RX FIFOs sit behind valid/ready streams. Line errors (parity, framing, overrun) are reported per byte or per event.

Parameters:
CLK_FREQ, 25_000_000, core_clk frequency in Hz
BAUDRATE, 115200, line rate in bit/s
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_EN, 0, 1 = append/check parity bit
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits sent, legal 1 or 2; RX always checks only the first
FIFO_DEPTH, 16, entries per FIFO, power of 2, >= 2

Ports:
core_clk  in  1  clock
core_rst_n  in  1  async active-low reset
tx_data_i  in  DATA_BITS  byte to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  TX FIFO not full
rx_data_o  out  DATA_BITS  head of RX FIFO
rx_parity_err_o  out  1  parity error flag of head entry, qualified by rx_valid_o
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  pop RX head
rx_frame_err_o  out  1  1-cycle pulse, frame dropped for bad stop bit
rx_overrun_o  out  1  1-cycle pulse, frame dropped because RX FIFO full
tx_level_o  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_level_o  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
tx_busy_o  out  1  TX FSM not IDLE
ser_tx  out  1  serial line out, idle high
ser_rx  in  1  serial line in, asynchronous

Behaviour:
- Reset (core_rst_n async, active-low; clock core_clk): ser_tx=1, tx_ready_o=1, rx_valid_o=0, tx_busy_o=0, levels=0, error pulses=0, both FIFOs emptied. Reset mid-frame aborts the frame immediately, and ser_tx goes high asynchronously.
- Divisor: DIV = (CLK_FREQ + BAUDRATE/2) / BAUDRATE, computed as an elaboration constant. Elaboration is fatal if DIV < 4. Default DIV = 217.
- FIFOs: show-ahead, registered. A push when full or a pop when empty is ignored. Simultaneous push and pop on a non-empty FIFO leaves the level unchanged. Read pointer wraps modulo FIFO_DEPTH.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when the FIFO is non-empty at stop end.
  - Each bit lasts exactly DIV cycles; STOP lasts STOP_BITS*DIV cycles.
  - Data is sent LSB first. Parity = XOR of data bits, XOR PARITY_ODD.
  - ser_tx is driven from a flop.
  - If the handshake completes at edge N with TX idle and the FIFO empty, the start bit appears on ser_tx after edge N+2.
  - Back-to-back frames have zero idle gap.
- RX sync: 2-flop synchroniser on ser_rx, both flops reset to 1.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - A synchronised falling edge in IDLE enters START and starts the bit counter.
  - START is sampled at DIV/2. If the sample is 1, the edge is a glitch: back to IDLE, no flags.
  - Each following bit is sampled DIV cycles after the previous sample.
  - RX returns to IDLE right after the stop sample, ready to resync on the next edge.
- RX at the stop sample:
  - Stop = 0: frame dropped, rx_frame_err_o pulses next cycle.
  - Otherwise, RX FIFO full: frame dropped, rx_overrun_o pulses next cycle.
  - Otherwise: {parity_err, data} is written, and rx_valid_o is high the next cycle.
  - Frame error takes precedence over overrun.
  - A parity mismatch does not drop the byte; it only sets the stored flag.
- DATA_BITS < 9: unused upper FIFO bits are not present.

Decomposition:
- Package uart_pkg holds:
  - tx_state_e and rx_state_e enums
  - function calc_div(clk_freq, baud)
  - level width helper
  - parameter legality checks
- Sub-module sync_fifo (params WIDTH, DEPTH) is instantiated twice:
  - TX: WIDTH = DATA_BITS
  - RX: WIDTH = DATA_BITS+1

Test Plan:
1. Defaults; push 0x68 at edge N -> ser_tx falls after N+2. Bits 0,0,0,1,0,1,1,0 follow, each 217 cycles, then 217 cycles high. tx_busy_o low afterwards.
2. Loopback ser_rx=ser_tx; push 0x55,0xAA,0x00,0xFF back-to-back -> 4 frames of 2170 cycles with no gap. RX pops the same 4 values in order with no error flags.
3. PARITY_EN=1, PARITY_ODD=1; bench drives 0x68 with parity bit 0 (correct is 0) -> rx_data_o 0x68, flag 0. Repeat with parity bit 1 -> rx_data_o 0x68, rx_parity_err_o=1.
4. Bench drives 0x41 with stop bit 0 -> rx_valid_o stays 0 and rx_frame_err_o pulses for exactly 1 cycle. Then a valid 0x42 is received normally.
5. rx_ready_i=0; send 17 frames 0x00..0x10 -> rx_level_o=16 and rx_overrun_o pulses once on frame 17. Pops return 0x00..0x0F.
6. ser_rx low for 50 cycles -> no frame, no flags. Assert reset mid TX data bit -> ser_tx=1 immediately, levels 0; after release the next push transmits cleanly.
